// File: rtl/avmm_lvds_bridge_pkg.sv
// Shared types and constants for the AVMM-to-LVDS bridge.
// Provides the request header layout, the transaction/burst encodings,
// the legal byteenable list and a helper that checks a byteenable value.
package avmm_lvds_bridge_pkg;

    localparam int ADDR_W    = 24;
    localparam int MAX_BURST = 16;
    localparam int BCNT_W    = $clog2(MAX_BURST + 1);

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [BCNT_W-1:0] burstcnt_t;

    typedef enum logic {
        TR_READ  = 1'b0,
        TR_WRITE = 1'b1
    } trans_e;

    typedef enum logic {
        NOBURST = 1'b0,
        BURST   = 1'b1
    } burst_e;

    // Header beat, MSB first. burstcnt_byteena carries the byteenable for
    // single-beat requests and the beat count for bursts.
    typedef struct packed {
        trans_e    tr;
        burst_e    burst;
        burstcnt_t burstcnt_byteena;
        address_t  address;
    } req_hdr_t;

    localparam int HDR_W = $bits(req_hdr_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_e;

    // Byte lanes a single-beat access may use: single bytes, aligned
    // halfwords and the full word.
    localparam int BE_LEGAL_N = 7;
    localparam logic [3:0] BE_LEGAL [BE_LEGAL_N] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
    };

    function automatic logic be_is_legal(input logic [3:0] be);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < BE_LEGAL_N; i++) begin
            if (be == BE_LEGAL[i]) begin
                ok = 1'b1;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/avmm_req_packetizer_if.sv
// Bus bundle for the request packetizer: the Avalon-MM slave command side
// (address, read, write, writedata, byteenable, burstcount, waitrequest)
// and the downstream packet stream (tx_data, tx_sop, tx_eop, tx_valid,
// tx_ready).
//   slave  : packetizer view (accepts AVMM commands, drives the stream)
//   master : environment view (issues AVMM commands, consumes the stream)
interface avmm_req_packetizer_if;
    import avmm_lvds_bridge_pkg::*;

    address_t    avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    burstcnt_t   avs_burstcount;
    logic        avs_waitrequest;

    logic [31:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_burstcount, tx_ready,
        output avs_waitrequest, tx_data, tx_sop, tx_eop, tx_valid
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_burstcount, tx_ready,
        input  avs_waitrequest, tx_data, tx_sop, tx_eop, tx_valid
    );

endinterface

// File: rtl/avmm_req_packetizer.sv
// Avalon-MM slave front end of the bridge TX path. Each AVMM command becomes
// a packet: one header beat (req_hdr_t zero-extended to 32 bits) followed,
// for writes only, by one beat per write data word. Commands with an illegal
// byteenable or burstcount are consumed without emitting anything and
// counted in a saturating error counter.
// Ports:
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : AVMM command side and packet stream (slave modport)
//   rd_issued  : one-cycle pulse when a read header lands in the tx slot
//   rd_len     : beats expected in the read response, valid with rd_issued
//   err_cnt    : saturating count of dropped requests
module avmm_req_packetizer
    import avmm_lvds_bridge_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    avmm_req_packetizer_if.slave bus,
    output logic                 rd_issued,
    output burstcnt_t            rd_len,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    if (HDR_W > 32) begin : g_hdr_too_wide
        $error("req_hdr_t does not fit in a 32-bit beat");
    end

    state_e               state_q, state_d;
    burstcnt_t            beats_left_q, beats_left_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]          tx_data_q, tx_data_d;
    logic                 tx_sop_q, tx_sop_d;
    logic                 tx_eop_q, tx_eop_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 rd_issued_q, rd_issued_d;
    burstcnt_t            rd_len_q, rd_len_d;
    logic                 run_q;

    logic     slot_free_s;
    logic     req_s;
    logic     bc_ok_s;
    logic     multi_s;
    logic     legal_s;
    logic     waitrequest_s;
    req_hdr_t hdr_s;

    // Request decode and header formation.
    always_comb begin
        slot_free_s = !tx_valid_q || bus.tx_ready;
        // run_q keeps the slave stalled while reset is applied and for the
        // first edge after release.
        req_s   = run_q && (bus.avs_read || bus.avs_write);
        bc_ok_s = (bus.avs_burstcount != '0) &&
                  (bus.avs_burstcount <= BCNT_W'(MAX_BURST));
        multi_s = bus.avs_burstcount > BCNT_W'(1);
        legal_s = bc_ok_s && (multi_s || be_is_legal(bus.avs_byteenable));

        hdr_s.tr      = bus.avs_read ? TR_READ : TR_WRITE;
        hdr_s.burst   = multi_s ? BURST : NOBURST;
        hdr_s.address = bus.avs_address;
        if (multi_s) begin
            hdr_s.burstcnt_byteena = bus.avs_burstcount;
        end else begin
            hdr_s.burstcnt_byteena = BCNT_W'(bus.avs_byteenable);
        end
    end

    // Next-state, slot load and waitrequest generation.
    always_comb begin
        state_d       = state_q;
        beats_left_d  = beats_left_q;
        err_cnt_d     = err_cnt_q;
        tx_data_d     = tx_data_q;
        tx_sop_d      = tx_sop_q;
        tx_eop_d      = tx_eop_q;
        tx_valid_d    = tx_valid_q && !bus.tx_ready;
        rd_issued_d   = 1'b0;
        rd_len_d      = rd_len_q;
        waitrequest_s = 1'b1;

        case (state_q)
            IDLE: begin
                if (req_s && !legal_s) begin
                    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
                    if (bus.avs_read) begin
                        waitrequest_s = 1'b0;
                    end else begin
                        // A zero burstcount still carries one data beat.
                        state_d      = DROP;
                        beats_left_d = bc_ok_s || multi_s ? bus.avs_burstcount
                                                          : BCNT_W'(1);
                    end
                end else if (req_s && slot_free_s) begin
                    tx_data_d  = 32'(hdr_s);
                    tx_sop_d   = 1'b1;
                    tx_valid_d = 1'b1;
                    if (bus.avs_read) begin
                        tx_eop_d      = 1'b1;
                        waitrequest_s = 1'b0;
                        rd_issued_d   = 1'b1;
                        rd_len_d      = bus.avs_burstcount;
                    end else begin
                        // Write data is held off until the header is in the slot.
                        tx_eop_d     = 1'b0;
                        beats_left_d = bus.avs_burstcount;
                        state_d      = DATA;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                waitrequest_s = !slot_free_s;
                if (bus.avs_write && slot_free_s) begin
                    tx_data_d    = bus.avs_writedata;
                    tx_sop_d     = 1'b0;
                    tx_eop_d     = (beats_left_q == BCNT_W'(1));
                    tx_valid_d   = 1'b1;
                    beats_left_d = beats_left_q - BCNT_W'(1);
                    if (beats_left_q == BCNT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            DROP: begin
                waitrequest_s = 1'b0;
                if (bus.avs_write) begin
                    beats_left_d = beats_left_q - BCNT_W'(1);
                    if (beats_left_q == BCNT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            err_cnt_q    <= '0;
            tx_data_q    <= 32'h0000_0000;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            rd_issued_q  <= 1'b0;
            rd_len_q     <= '0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            err_cnt_q    <= err_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_sop_q     <= tx_sop_d;
            tx_eop_q     <= tx_eop_d;
            tx_valid_q   <= tx_valid_d;
            rd_issued_q  <= rd_issued_d;
            rd_len_q     <= rd_len_d;
            run_q        <= 1'b1;
        end
    end

    assign bus.avs_waitrequest = waitrequest_s;
    assign bus.tx_data         = tx_data_q;
    assign bus.tx_sop          = tx_sop_q;
    assign bus.tx_eop          = tx_eop_q;
    assign bus.tx_valid        = tx_valid_q;
    assign rd_issued           = rd_issued_q;
    assign rd_len              = rd_len_q;
    assign err_cnt             = err_cnt_q;

endmodule
